// File: rtl/alu_pkg.sv
// alu_pkg: shared ALUCtrl codes, FSM state encoding and shift-amount width for the execute-stage ALU
package alu_pkg;
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b01010;
    localparam logic [4:0] ALU_XOR = 5'b00100;
    localparam logic [4:0] ALU_SLT = 5'b01011;
    localparam logic [4:0] ALU_SLL = 5'b00110;
    localparam logic [4:0] ALU_SRL = 5'b00111;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam int SHAMT_W = 5;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    function automatic logic is_shift(input logic [4:0] code);
        return code == ALU_SLL || code == ALU_SRL || code == ALU_SRA;
    endfunction
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: shift engine for the execute-stage ALU, iterative (1 bit/cycle) or barrel with ALU_FAST_SHIFT_EN
//   clk, rst : clock and async active-high reset (iterative build only)
//   start    : load a/amt/op and begin shifting
//   op       : ALUCtrl shift code (SLL/SRL/SRA)
//   a, amt   : value to shift and shift amount
//   res      : iterative: working register shifted one more bit; barrel: full result
//   busy     : counter non-zero (always 0 in the barrel build)
//   done     : iterative: the coming edge performs the final shift; barrel: mirrors start
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifndef ALU_FAST_SHIFT_EN
    input  logic               clk,
    input  logic               rst,
`endif
    input  logic               start,
    input  logic [4:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] amt,
    output logic [WIDTH-1:0]   res,
    output logic               busy,
    output logic               done
);
`ifdef ALU_FAST_SHIFT_EN
    always_comb begin
        res  = op == ALU_SLL ? a << amt : op == ALU_SRA ? $unsigned($signed(a) >>> amt) : a >> amt;
        busy = 1'b0;
        done = start;
    end
`else
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [4:0]         op_q;
    // res is the next value of work, so the parent can register the final
    // result on the same edge the counter reaches zero
    always_comb begin
        res  = op_q == ALU_SLL ? {work[WIDTH-2:0], 1'b0} : {op_q == ALU_SRA && work[WIDTH-1], work[WIDTH-1:1]};
        busy = cnt != '0;
        done = cnt == SHAMT_W'(1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= '0;
            cnt  <= '0;
            op_q <= ALU_SLL;
        end else if (start) begin
            work <= a;
            cnt  <= amt;
            op_q <= op;
        end else if (busy) begin
            work <= res;
            cnt  <= cnt - SHAMT_W'(1);
        end
    end
`endif
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute-stage ALU with valid/ready handshake; ALU_FAST_SHIFT_EN selects barrel shifts
//   clk, rst             : clock and async active-high reset
//   in_valid, in_ready   : operation handshake (ALUCtrl, OpA, OpB)
//   out_valid, out_ready : result handshake (Result, Zero, Illegal)
//   Result, Zero, Illegal: registered result, Result==0 flag, undefined-code flag
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUCtrl,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Illegal
);
    state_t             state, state_n;
    logic               accept, shift_op, long_shift, legal, load, load_sh, start, sh_busy, sh_done;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   res, sh_res, sh_now, res_n;

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
`ifndef ALU_FAST_SHIFT_EN
        .clk  (clk),
        .rst  (rst),
`endif
        .start(start),
        .op   (ALUCtrl),
        .a    (OpA),
        .amt  (amt),
        .res  (sh_res),
        .busy (sh_busy),
        .done (sh_done)
    );

    always_comb begin
        amt      = OpB[SHAMT_W-1:0];
        shift_op = is_shift(ALUCtrl);
        legal    = shift_op || ALUCtrl inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT};
`ifdef ALU_FAST_SHIFT_EN
        long_shift = 1'b0;
        sh_now     = sh_res;
`else
        // a zero-amount shift needs no iterations and takes the single-cycle path
        long_shift = shift_op && amt != '0;
        sh_now     = OpA;
`endif
        res = ALUCtrl == ALU_AND ? OpA & OpB :
              ALUCtrl == ALU_OR  ? OpA | OpB :
              ALUCtrl == ALU_ADD ? OpA + OpB :
              ALUCtrl == ALU_SUB ? OpA - OpB :
              ALUCtrl == ALU_XOR ? OpA ^ OpB :
              ALUCtrl == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(OpA) < $signed(OpB)} :
              shift_op           ? sh_now : '0;
        in_ready  = state == IDLE || (state == DONE && out_ready);
        out_valid = state == DONE;
        accept    = in_valid && in_ready;
        start     = accept && long_shift;
        load      = accept && !long_shift;
        // leaving on !sh_busy as well keeps SHIFT from ever stalling on an empty counter
        load_sh   = state == SHIFT && (sh_done || !sh_busy);
        res_n     = load_sh ? sh_res : res;
        state_n   = accept                         ? (long_shift ? SHIFT : DONE) :
                    load_sh                        ? DONE :
                    (state == DONE && out_ready)   ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            Result  <= '0;
            Zero    <= 1'b0;
            Illegal <= 1'b0;
        end else begin
            state <= state_n;
            if (load || load_sh) begin
                Result  <= res_n;
                Zero    <= res_n == '0;
                Illegal <= load && !legal;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomised scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, Zero, Illegal;
    logic [4:0]  ALUCtrl = '0;
    logic [31:0] OpA = '0, OpB = '0, Result;
    int          checks = 0, failures = 0;
    logic [33:0] sb[$];
    string       tq[$];
    logic [33:0] exp_word;
    string       exp_tag;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ALUCtrl(ALUCtrl),
        .OpA(OpA), .OpB(OpB), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Zero(Zero), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [32:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            5'b00000: return {1'b0, a & b};
            5'b00001: return {1'b0, a | b};
            5'b00010: return {1'b0, a + b};
            5'b01010: return {1'b0, a - b};
            5'b00100: return {1'b0, a ^ b};
            5'b01011: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            5'b00110: return {1'b0, a << b[4:0]};
            5'b00111: return {1'b0, a >> b[4:0]};
            5'b00101: return {1'b0, $unsigned($signed(a) >>> b[4:0])};
            default:  return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic il, input string t);
        in_valid = v;
        ALUCtrl  = c;
        OpA      = a;
        OpB      = b;
        exp_word = {il, r == 32'd0, r};
        exp_tag  = t;
    endtask

    // one clock: score a result the consumer takes, record an accepted op, then advance
    task automatic step();
        #1;
        if (out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_output observed=%0h expected=none", {Illegal, Zero, Result});
            end
            if (sb.size() != 0) chk(tq.pop_front(), {30'd0, Illegal, Zero, Result}, {30'd0, sb.pop_front()});
        end
        if (in_valid && in_ready) begin
            sb.push_back(exp_word);
            tq.push_back(exp_tag);
        end
        @(posedge clk);
        #1;
    endtask

    // isolated op: accept, count edges until out_valid (in_ready must stay low meanwhile), then consume
    task automatic run_one(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic il, input int lat, input string t);
        int n;
        out_ready = 1'b1;
        drive(1'b1, c, a, b, r, il, t);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            chk({t, "_in_ready_busy"}, in_ready, 0);
            step();
            n++;
        end
        chk({t, "_latency"}, n, lat);
        step();
    endtask

    initial begin
        logic [32:0] m;
        logic [4:0]  codes[10];
        logic [4:0]  c;
        logic [31:0] a, b;
        int          n;
        logic        seen;
        codes = '{5'b00000, 5'b00001, 5'b00010, 5'b01010, 5'b00100, 5'b01011, 5'b00110, 5'b00111, 5'b00101, 5'b11111};

        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", Result, 0);
        chk("reset_zero", Zero, 0);
        chk("reset_illegal", Illegal, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // back-to-back single-cycle ops
        out_ready = 1'b1;
        drive(1'b1, 5'b00010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, "add_ovf");
        step();
        chk("tp_valid_1", out_valid, 1);
        chk("tp_ready_1", in_ready, 1);
        drive(1'b1, 5'b01010, 32'd5, 32'd5, 32'd0, 1'b0, "sub_zero");
        step();
        chk("tp_valid_2", out_valid, 1);
        chk("tp_ready_2", in_ready, 1);
        in_valid = 1'b0;
        step();
        chk("tp_idle_valid", out_valid, 0);

        run_one(5'b01011, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0, "slt_neg_pos");
        run_one(5'b01011, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, "slt_pos_neg");
        run_one(5'b00100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 0, "xor");
        run_one(5'b00001, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b0, 0, "or");
`ifdef ALU_FAST_SHIFT_EN
        run_one(5'b00101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 0, "sra_4");
        run_one(5'b00111, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 0, "srl_31");
        run_one(5'b00110, 32'h8000_0001, 32'd1, 32'h2, 1'b0, 0, "sll_1");
`else
        run_one(5'b00101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 4, "sra_4");
        run_one(5'b00111, 32'h8000_0000, 32'd31, 32'h1, 1'b0, 31, "srl_31");
        run_one(5'b00110, 32'h8000_0001, 32'd1, 32'h2, 1'b0, 1, "sll_1");
`endif
        run_one(5'b00110, 32'h1, 32'hFFFF_FFE0, 32'h1, 1'b0, 0, "sll_0");
        run_one(5'b11111, 32'd3, 32'd4, 32'd0, 1'b1, 0, "illegal");

        // backpressure with a pending op waiting on in_ready
        out_ready = 1'b0;
        drive(1'b1, 5'b00000, 32'h0000_0FF0, 32'h0000_00FF, 32'h0000_00F0, 1'b0, "and_bp");
        step();
        drive(1'b1, 5'b00001, 32'h1, 32'h2, 32'h3, 1'b0, "or_pending");
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_result", Result, 32'h0000_00F0);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_pending_taken", out_valid, 1);
        step();

        // reset in the middle of a 20-bit shift drops the op
        drive(1'b1, 5'b00110, 32'h1, 32'd20, 32'h0010_0000, 1'b0, "sll_20_dropped");
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_result", Result, 0);
        chk("rst_mid_zero", Zero, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        sb.delete();
        tq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("rst_no_stale", seen, 0);

        // random mix with random backpressure
        for (int i = 0; i < 60; i++) begin
            c = codes[$urandom_range(0, 9)];
            a = $urandom();
            b = $urandom() & ~32'h18;
            m = model(c, a, b);
            drive(1'($urandom_range(0, 1)), c, a, b, m[31:0], m[32], "rand");
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
